// File: rtl/td4_pkg.sv
// Shared TD4 program-memory geometry and loader FSM state encoding.
package td4_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned INSTR_W    = 8;

  typedef enum logic [2:0] {
    StRun,
    StLoad,
    StCheck,
    StHold,
    StErr
  } loader_state_e;

endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 program store: synchronous clear and write, asynchronous read.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [PROG_DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program loader: byte-stream program upload with checksum, timeout and CPU reset hold.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] instr,
  input  logic               load_start,
  input  logic [INSTR_W-1:0] rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               cpu_n_reset,
  output logic               busy,
  output logic               load_ok,
  output logic               load_err
);

  localparam int unsigned TcntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TcntW-1:0]  TcntLast = TcntW'(TIMEOUT_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldInit = HoldW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PtrLast  = ADDR_W'(PROG_DEPTH - 1);

  loader_state_e      state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [INSTR_W-1:0] sum_q, sum_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               cpu_n_reset_q, cpu_n_reset_d;
  logic               xfer;
  logic               mem_we;
  logic [INSTR_W-1:0] sum_next;

  assign rx_ready = (state_q == StLoad) || (state_q == StCheck);
  assign xfer     = rx_valid && rx_ready;
  assign sum_next = sum_q + rx_data;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    ok_d    = ok_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    // A start pulse wins over everything, including a same-cycle byte, which is dropped.
    if (load_start) begin
      state_d = StLoad;
      ptr_d   = '0;
      sum_d   = '0;
      tcnt_d  = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StRun: ;
        StLoad: begin
          if (xfer) begin
            mem_we = 1'b1;
            sum_d  = sum_next;
            ptr_d  = ptr_q + 1'b1;
            tcnt_d = '0;
            if (ptr_q == PtrLast) state_d = StCheck;
          end else if (tcnt_q == TcntLast) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StCheck: begin
          if (xfer) begin
            tcnt_d = '0;
            if (sum_next == '0) begin
              state_d = StHold;
              hold_d  = HoldInit;
              ok_d    = 1'b1;
            end else begin
              state_d = StErr;
              err_d   = 1'b1;
            end
          end else if (tcnt_q == TcntLast) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StHold: begin
          if (hold_q == '0) state_d = StRun;
          else              hold_d  = hold_q - 1'b1;
        end
        StErr: ;
        default: state_d = StHold;
      endcase
    end
    cpu_n_reset_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHold;
      hold_q        <= HoldInit;
      tcnt_q        <= '0;
      ptr_q         <= '0;
      sum_q         <= '0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      cpu_n_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      tcnt_q        <= tcnt_d;
      ptr_q         <= ptr_d;
      sum_q         <= sum_d;
      ok_q          <= ok_d;
      err_q         <= err_d;
      cpu_n_reset_q <= cpu_n_reset_d;
    end
  end

  td4_prog_mem u_mem (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (mem_we),
    .waddr_i (ptr_q),
    .wdata_i (rx_data),
    .raddr_i (address),
    .rdata_o (instr)
  );

  assign cpu_n_reset = cpu_n_reset_q;
  assign busy        = (state_q != StRun);
  assign load_ok     = ok_q;
  assign load_err    = err_q;

endmodule
